// File: rtl/gcd_binary_pkg.sv
// Shared types and sizing helpers for the binary GCD engine.
package gcd_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        STRIP,
        ODDA,
        LOOP,
        DONE
    } gcd_state_e;

    // Worst case is 6*WIDTH+4 cycles after accept, so the counter must hold that value.
    function automatic int cnt_width(input int width);
        return $clog2(6 * width + 5);
    endfunction

endpackage

// File: rtl/gcd_binary_if.sv
// Host-side start/done bus of the binary GCD engine.
interface gcd_binary_if import gcd_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    localparam int CNT_W = cnt_width(WIDTH);

    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             zero_err;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, abort, a_in, b_in,
        input  ready, result, done, zero_err, cycles
    );

    modport slave (
        input  start, abort, a_in, b_in,
        output ready, result, done, zero_err, cycles
    );

endinterface

// File: rtl/gcd_binary_dp.sv
// Operand registers, common-power-of-two counter and the shift/subtract step of Stein's algorithm.
module gcd_binary_dp import gcd_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  gcd_state_e       state,
    input  logic             load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a_zero,
    output logic             b_zero,
    output logic             a_odd,
    output logic             b_odd,
    output logic [WIDTH-1:0] a_or_b,
    output logic [WIDTH-1:0] gcd_val
);
    localparam int KW = $clog2(WIDTH);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a <= '0;
            b <= '0;
            k <= '0;
        end else if (load) begin
            a <= a_in;
            b <= b_in;
            k <= '0;
        end else begin
            case (state)
                STRIP: begin
                    if (!a[0] && !b[0]) begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + KW'(1);
                    end
                end
                ODDA: begin
                    if (!a[0]) a <= a >> 1;
                end
                LOOP: begin
                    // a stays odd; the swap keeps the smaller odd value in a so b-a never underflows
                    if (b != '0) begin
                        if (!b[0]) begin
                            b <= b >> 1;
                        end else if (a > b) begin
                            a <= b;
                            b <= a - b;
                        end else begin
                            b <= b - a;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_zero  = (a == '0);
    assign b_zero  = (b == '0);
    assign a_odd   = a[0];
    assign b_odd   = b[0];
    assign a_or_b  = a | b;
    assign gcd_val = a << k;

endmodule

// File: rtl/gcd_binary.sv
// Binary (Stein) GCD engine: sequencing FSM, cycle counter and registered result outputs.
//
// state | meaning
// IDLE  | ready, waiting for start
// CHECK | detect zero operands
// STRIP | remove common factors of two, counting them in k
// ODDA  | shift a until odd
// LOOP  | reduce b against odd a until b is zero
// DONE  | one-cycle done pulse, outputs valid
module gcd_binary import gcd_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    gcd_binary_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    gcd_state_e       state;
    gcd_state_e       state_next;
    logic             load;
    logic             a_zero;
    logic             b_zero;
    logic             a_odd;
    logic             b_odd;
    logic [WIDTH-1:0] a_or_b;
    logic [WIDTH-1:0] gcd_val;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cycles_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_err_q;
    logic             done_q;

    assign load = (state == IDLE) && bus.start && !bus.abort;

    gcd_binary_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .reset   (reset),
        .state   (state),
        .load    (load),
        .a_in    (bus.a_in),
        .b_in    (bus.b_in),
        .a_zero  (a_zero),
        .b_zero  (b_zero),
        .a_odd   (a_odd),
        .b_odd   (b_odd),
        .a_or_b  (a_or_b),
        .gcd_val (gcd_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CHECK;
            CHECK:   state_next = (a_zero || b_zero) ? DONE : STRIP;
            STRIP:   if (a_odd || b_odd) state_next = ODDA;
            ODDA:    if (a_odd) state_next = LOOP;
            LOOP:    if (b_zero) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.abort && state != IDLE) state_next = IDLE;
    end

    // Results are captured on the way into DONE so they are valid in the same cycle as done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            cycles_q   <= '0;
            result_q   <= '0;
            zero_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_next == DONE);
            if (load)               cnt <= CNT_W'(1);
            else if (state != IDLE) cnt <= cnt + CNT_W'(1);
            if (state_next == DONE) begin
                cycles_q <= cnt + CNT_W'(1);
                if (state == CHECK) begin
                    result_q   <= a_or_b;
                    zero_err_q <= (a_or_b == '0);
                end else begin
                    result_q   <= gcd_val;
                    zero_err_q <= 1'b0;
                end
            end
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.zero_err = zero_err_q;
    assign bus.cycles   = cycles_q;

endmodule

// File: tb/tb_gcd_binary.sv
// Directed checks of the binary GCD engine at WIDTH=32 plus a sampled sweep at WIDTH=8.
module tb_gcd_binary;
    import gcd_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    gcd_binary_if #(.WIDTH(32)) b32 ();
    gcd_binary_if #(.WIDTH(8))  b8 ();

    gcd_binary #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    gcd_binary #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned ref_gcd(input longint unsigned x, input longint unsigned y);
        longint unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic start32(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("ready_before_start", b32.ready, 1);
        b32.a_in  = a;
        b32.b_in  = b;
        b32.start = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
    endtask

    task automatic wait32(input int lat0, output int lat);
        lat = lat0;
        while (!b32.done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen32", b32.done, 1);
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input logic exp_z, input string tag, output int lat);
        start32(a, b);
        wait32(1, lat);
        check({tag, "_result"}, b32.result, exp);
        check({tag, "_zero_err"}, b32.zero_err, exp_z);
        check({tag, "_cycles"}, b32.cycles, lat);
        check({tag, "_bound"}, lat <= 196, 1);
        @(negedge clk);
        check({tag, "_pulse"}, b32.done, 0);
        check({tag, "_held"}, b32.result, exp);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        logic [7:0] exp;
        exp = 8'(ref_gcd(64'(a), 64'(b)));
        @(negedge clk);
        check("ready8", b8.ready, 1);
        b8.a_in  = a;
        b8.b_in  = b;
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        lat = 1;
        while (!b8.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen8", b8.done, 1);
        check("w8_result", b8.result, exp);
        check("w8_zero_err", b8.zero_err, (a == 0 && b == 0));
        check("w8_bound52", lat <= 52, 1);
        @(negedge clk);
        check("w8_pulse", b8.done, 0);
    endtask

    initial begin
        int lat;
        int any_done;
        logic [31:0] prev_result;
        logic [7:0]  prev_cycles;

        reset = 1'b1;
        b32.start = 1'b0; b32.abort = 1'b0; b32.a_in = '0; b32.b_in = '0;
        b8.start  = 1'b0; b8.abort  = 1'b0; b8.a_in  = '0; b8.b_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", b32.ready, 1);
        check("rst_result", b32.result, 0);
        check("rst_done", b32.done, 0);
        check("rst_zero_err", b32.zero_err, 0);
        check("rst_cycles", b32.cycles, 0);
        reset = 1'b0;

        op32(48, 18, 6, 1'b0, "basic", lat);
        op32(0, 7, 7, 1'b0, "zero_a", lat);
        check("zero_a_lat2", lat, 2);
        op32(7, 0, 7, 1'b0, "zero_b", lat);
        check("zero_b_lat2", lat, 2);
        op32(0, 0, 0, 1'b1, "both_zero", lat);
        check("both_zero_lat2", lat, 2);
        repeat (3) @(negedge clk);
        check("zero_err_held", b32.zero_err, 1);
        op32(1024, 4096, 1024, 1'b0, "pow2", lat);
        op32(32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, "max_vs_msb", lat);
        op32(17, 17, 17, 1'b0, "equal", lat);

        // start while busy must not disturb the operation in flight
        start32(100, 75);
        repeat (2) @(negedge clk);
        check("busy_ready_low", b32.ready, 0);
        b32.a_in  = 9;
        b32.b_in  = 3;
        b32.start = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        wait32(4, lat);
        check("busy_result", b32.result, 25);
        check("busy_cycles", b32.cycles, lat);
        any_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (b32.done) any_done++;
        end
        check("busy_no_second_done", any_done, 0);

        prev_result = b32.result;
        prev_cycles = b32.cycles;
        start32(1071, 462);
        any_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (b32.done) any_done++;
        end
        b32.abort = 1'b1;
        @(negedge clk);
        b32.abort = 1'b0;
        check("abort_ready", b32.ready, 1);
        check("abort_result_held", b32.result, prev_result);
        check("abort_cycles_held", b32.cycles, prev_cycles);
        repeat (60) begin
            @(negedge clk);
            if (b32.done) any_done++;
        end
        check("abort_no_done", any_done, 0);

        start32(1071, 462);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", b32.ready, 1);
        check("mid_rst_result", b32.result, 0);
        check("mid_rst_done", b32.done, 0);
        check("mid_rst_zero_err", b32.zero_err, 0);
        check("mid_rst_cycles", b32.cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        any_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (b32.done) any_done++;
        end
        check("mid_rst_no_done", any_done, 0);
        op32(1071, 462, 21, 1'b0, "fresh", lat);

        for (int i = 0; i < 256; i += 15) begin
            for (int j = 0; j < 256; j += 17) begin
                op8(8'(i), 8'(j));
            end
        end
        op8(8'd255, 8'd128);
        op8(8'd128, 8'd64);
        op8(8'd0, 8'd0);
        op8(8'd254, 8'd127);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
